// File: rtl/hpi_pkg.sv
// rtl/hpi_pkg.sv - shared types and constants for the HPI bus sequencer
package hpi_pkg;

  // Access phases, walked in declaration order once a request is taken.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } hpi_state_e;

  // Phase length counter; every phase is 1..15 cycles long.
  typedef logic [3:0] phase_cnt_t;

  // HPI register map as seen on otg_addr.
  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

  // Default bus timing in clock cycles.
  localparam int DEF_SETUP_CYC    = 1;
  localparam int DEF_STROBE_CYC   = 2;
  localparam int DEF_HOLD_CYC     = 1;
  localparam int DEF_RECOVERY_CYC = 2;

endpackage

// File: rtl/hpi_bus_sequencer_if.sv
// rtl/hpi_bus_sequencer_if.sv - Avalon-MM slave side and HPI pin side of the sequencer
interface hpi_bus_sequencer_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        waitrequest;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;
  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;

  // The sequencer itself.
  modport slave (
    input  chipselect, address, read, write, writedata, otg_data_in,
    output readdata, waitrequest, otg_addr, otg_data_out, otg_data_oe,
           otg_cs_n, otg_rd_n, otg_wr_n
  );

  // The Avalon host together with the HPI device model.
  modport master (
    output chipselect, address, read, write, writedata, otg_data_in,
    input  readdata, waitrequest, otg_addr, otg_data_out, otg_data_oe,
           otg_cs_n, otg_rd_n, otg_wr_n
  );
endinterface

// File: rtl/hpi_phase_counter.sv
// rtl/hpi_phase_counter.sv - loadable down-counter timing one bus phase
module hpi_phase_counter
  import hpi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  phase_cnt_t load_val,
  output logic       last
);

  phase_cnt_t count;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - phase_cnt_t'(1);
  end

  assign last = (count == '0);

endmodule

// File: rtl/hpi_bus_sequencer.sv
// rtl/hpi_bus_sequencer.sv - Avalon-MM to HPI strobe sequencer
module hpi_bus_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC
) (
  input logic                clk,
  input logic                reset,
  hpi_bus_sequencer_if.slave bus
);

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam phase_cnt_t SETUP_LOAD    = phase_cnt_t'(SETUP_CYC - 1);
  localparam phase_cnt_t STROBE_LOAD   = phase_cnt_t'(STROBE_CYC - 1);
  localparam phase_cnt_t HOLD_LOAD     = phase_cnt_t'(HOLD_CYC - 1);
  localparam phase_cnt_t RECOVERY_LOAD = phase_cnt_t'(RECOVERY_CYC - 1);

  hpi_state_e  state, next_state;
  logic        request, done, last, load;
  phase_cnt_t  load_val;
  logic        next_write, next_active;
  logic        lat_write;
  logic [1:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] rdata_q;
  logic        cs_n_q, rd_n_q, wr_n_q, oe_q;

  assign request = bus.chipselect & (bus.read | bus.write);
  assign done    = (state == ST_HOLD) & last;

  hpi_phase_counter u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next phase and counter reload on each phase change.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = '0;
    case (state)
      ST_IDLE: if (request) begin
        next_state = ST_SETUP;   load = 1'b1; load_val = SETUP_LOAD;
      end
      ST_SETUP: if (last) begin
        next_state = ST_STROBE;  load = 1'b1; load_val = STROBE_LOAD;
      end
      ST_STROBE: if (last) begin
        next_state = ST_HOLD;    load = 1'b1; load_val = HOLD_LOAD;
      end
      ST_HOLD: if (last) begin
        next_state = ST_RECOVER; load = 1'b1; load_val = RECOVERY_LOAD;
      end
      ST_RECOVER: if (last) begin
        next_state = ST_IDLE;    load = 1'b1; load_val = '0;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Direction of the access the outputs are being decoded for; in IDLE
  // that is the request being accepted on this edge (write wins).
  assign next_write  = (state == ST_IDLE) ? bus.write : lat_write;
  assign next_active = (next_state == ST_SETUP) || (next_state == ST_STROBE) ||
                       (next_state == ST_HOLD);

  // Capture the request once on IDLE exit; frozen until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == ST_IDLE && request) begin
      lat_write <= bus.write;
      lat_addr  <= bus.address;
      lat_wdata <= bus.writedata;
    end
  end

  // HPI strobes and output enable, registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      oe_q   <= 1'b0;
    end else begin
      cs_n_q <= ~next_active;
      rd_n_q <= ~((next_state == ST_STROBE) & ~next_write);
      wr_n_q <= ~((next_state == ST_STROBE) & next_write);
      oe_q   <= next_active & next_write;
    end
  end

  // Read data is sampled on the edge that ends the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rdata_q <= '0;
    else if (state == ST_STROBE && last && !lat_write)
      rdata_q <= bus.otg_data_in;
  end

  assign bus.waitrequest  = request & ~done;
  assign bus.readdata     = rdata_q;
  assign bus.otg_addr     = lat_addr;
  assign bus.otg_data_out = lat_wdata;
  assign bus.otg_data_oe  = oe_q;
  assign bus.otg_cs_n     = cs_n_q;
  assign bus.otg_rd_n     = rd_n_q;
  assign bus.otg_wr_n     = wr_n_q;

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// tb/tb_hpi_bus_sequencer.sv - self-checking bench for hpi_bus_sequencer
module tb_hpi_bus_sequencer;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
  } in_t;

  typedef struct {
    in_t         in;
    logic [38:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hpi_bus_sequencer_if ifa ();
  hpi_bus_sequencer_if ifb ();

  hpi_bus_sequencer dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  hpi_bus_sequencer #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2), .RECOVERY_CYC(1))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  in_t cur [2];

  assign ifa.chipselect  = cur[0].cs;
  assign ifa.read        = cur[0].rd;
  assign ifa.write       = cur[0].wr;
  assign ifa.address     = cur[0].addr;
  assign ifa.writedata   = cur[0].wdata;
  assign ifa.otg_data_in = cur[0].din;
  assign ifb.chipselect  = cur[1].cs;
  assign ifb.read        = cur[1].rd;
  assign ifb.write       = cur[1].wr;
  assign ifb.address     = cur[1].addr;
  assign ifb.writedata   = cur[1].wdata;
  assign ifb.otg_data_in = cur[1].din;

  // {cs_n, rd_n, wr_n, oe, waitrequest, otg_addr, otg_data_out, readdata}
  wire [38:0] out_a = {ifa.otg_cs_n, ifa.otg_rd_n, ifa.otg_wr_n, ifa.otg_data_oe,
                       ifa.waitrequest, ifa.otg_addr, ifa.otg_data_out, ifa.readdata};
  wire [38:0] out_b = {ifb.otg_cs_n, ifb.otg_rd_n, ifb.otg_wr_n, ifb.otg_data_oe,
                       ifb.waitrequest, ifb.otg_addr, ifb.otg_data_out, ifb.readdata};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: m_k counts cycles since the accepting edge (0 = idle).
  int          s_cyc [2];
  int          p_cyc [2];
  int          h_cyc [2];
  int          r_cyc [2];
  int          m_k   [2];
  logic        m_w   [2];
  logic [1:0]  m_addr[2];
  logic [15:0] m_data[2];
  logic [15:0] m_rd  [2];

  function automatic logic [38:0] get_out(int d);
    return (d == 0) ? out_a : out_b;
  endfunction

  function automatic in_t mk(bit c, bit r, bit w, logic [1:0] a, logic [15:0] wd, logic [15:0] di);
    in_t t;
    t.cs = c; t.rd = r; t.wr = w; t.addr = a; t.wdata = wd; t.din = di;
    return t;
  endfunction

  function automatic logic [38:0] ex(bit cs_n, bit rd_n, bit wr_n, bit oe, bit wt,
                                     logic [1:0] a, logic [15:0] dout, logic [15:0] rdv);
    return {cs_n, rd_n, wr_n, oe, wt, a, dout, rdv};
  endfunction

  function automatic logic [38:0] model_out(int d);
    int  k       = m_k[d];
    int  act_end = s_cyc[d] + p_cyc[d] + h_cyc[d];
    bit  active  = (k >= 1) && (k <= act_end);
    bit  strobe  = (k > s_cyc[d]) && (k <= s_cyc[d] + p_cyc[d]);
    bit  done    = (k == act_end);
    bit  req     = cur[d].cs & (cur[d].rd | cur[d].wr);
    return ex(!active, !(strobe && !m_w[d]), !(strobe && m_w[d]), active && m_w[d],
              req && !done, m_addr[d], m_data[d], m_rd[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_k[d] = 0; m_w[d] = 1'b0; m_addr[d] = '0; m_data[d] = '0; m_rd[d] = '0;
    end
  endtask

  task automatic model_step(int d);
    bit req = cur[d].cs & (cur[d].rd | cur[d].wr);
    if (m_k[d] == 0) begin
      if (req) begin
        m_k[d] = 1; m_w[d] = cur[d].wr; m_addr[d] = cur[d].addr; m_data[d] = cur[d].wdata;
      end
    end else begin
      if (m_k[d] == s_cyc[d] + p_cyc[d] && !m_w[d]) m_rd[d] = cur[d].din;
      m_k[d] = (m_k[d] == s_cyc[d] + p_cyc[d] + h_cyc[d] + r_cyc[d]) ? 0 : m_k[d] + 1;
    end
  endtask

  task automatic check(string name, logic [38:0] act, logic [38:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_int(string name, int act, int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic apply(in_t a, in_t b);
    cur[0] = a;
    cur[1] = b;
    #1;
  endtask

  task automatic check_model(string tag);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s dut%0d", tag, d), get_out(d), model_out(d));
  endtask

  task automatic advance();
    for (int d = 0; d < 2; d++) model_step(d);
    @(negedge clk);
  endtask

  vec_t tbl[$];

  task automatic add(in_t i, logic [38:0] e);
    vec_t v;
    v.in = i; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    in_t idle, w, r, rb, ri, b, w2, wc, wb;
    int  first_low, first_wait, strobe_cnt;
    logic [38:0] o;

    s_cyc = '{1, 3}; p_cyc = '{2, 4}; h_cyc = '{1, 2}; r_cyc = '{2, 1};
    idle = mk(0, 0, 0, 2'd0, 16'h0, 16'h0);
    cur[0] = idle; cur[1] = idle;
    model_reset();

    // Directed vectors: default write, read, then read+write together.
    w  = mk(1, 0, 1, 2'd2, 16'h1000, 16'h0000);
    add(w,    ex(1,1,1,0,1, 2'd0, 16'h0000, 16'h0000));
    add(w,    ex(0,1,1,1,1, 2'd2, 16'h1000, 16'h0000));
    add(w,    ex(0,1,0,1,1, 2'd2, 16'h1000, 16'h0000));
    add(w,    ex(0,1,0,1,1, 2'd2, 16'h1000, 16'h0000));
    add(w,    ex(0,1,1,1,0, 2'd2, 16'h1000, 16'h0000));
    for (int i = 0; i < 3; i++) add(idle, ex(1,1,1,0,0, 2'd2, 16'h1000, 16'h0000));
    r  = mk(1, 1, 0, 2'd0, 16'h5555, 16'h1234);
    rb = mk(1, 1, 0, 2'd0, 16'h5555, 16'hBEEF);
    ri = mk(0, 0, 0, 2'd0, 16'h0000, 16'h1234);
    add(r,    ex(1,1,1,0,1, 2'd2, 16'h1000, 16'h0000));
    add(r,    ex(0,1,1,0,1, 2'd0, 16'h5555, 16'h0000));
    add(rb,   ex(0,0,1,0,1, 2'd0, 16'h5555, 16'h0000));
    add(rb,   ex(0,0,1,0,1, 2'd0, 16'h5555, 16'h0000));
    add(r,    ex(0,1,1,0,0, 2'd0, 16'h5555, 16'hBEEF));
    for (int i = 0; i < 3; i++) add(ri, ex(1,1,1,0,0, 2'd0, 16'h5555, 16'hBEEF));
    b  = mk(1, 1, 1, 2'd1, 16'hA5A5, 16'h0F0F);
    add(b,    ex(1,1,1,0,1, 2'd0, 16'h5555, 16'hBEEF));
    add(b,    ex(0,1,1,1,1, 2'd1, 16'hA5A5, 16'hBEEF));
    add(b,    ex(0,1,0,1,1, 2'd1, 16'hA5A5, 16'hBEEF));
    add(b,    ex(0,1,0,1,1, 2'd1, 16'hA5A5, 16'hBEEF));
    add(b,    ex(0,1,1,1,0, 2'd1, 16'hA5A5, 16'hBEEF));
    for (int i = 0; i < 3; i++) add(idle, ex(1,1,1,0,0, 2'd1, 16'hA5A5, 16'hBEEF));

    // Reset state, then release so the first row meets the first edge.
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("reset dut0", out_a, ex(1,1,1,0,0, 2'd0, 16'h0, 16'h0));
    check("reset dut1", out_b, ex(1,1,1,0,0, 2'd0, 16'h0, 16'h0));
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].in, idle);
      check($sformatf("vec%0d", i), out_a, tbl[i].exp);
      advance();
    end

    // Back-to-back writes: second SETUP waits for recovery and IDLE.
    w2 = mk(1, 0, 1, 2'd3, 16'h2222, 16'h0);
    first_low = -1;
    for (int c = 0; c <= 8; c++) begin
      apply(w2, idle);
      check_model($sformatf("b2b c%0d", c));
      if (c >= 5 && first_low < 0 && out_a[38] == 1'b0) first_low = c;
      advance();
    end
    check_int("b2b second setup cycle", first_low, 8);
    for (int c = 0; c < 8; c++) begin
      apply(idle, idle);
      check_model($sformatf("b2b drain c%0d", c));
      advance();
    end

    // Reset in the middle of a write strobe, request kept asserted.
    wc = mk(1, 0, 1, 2'd3, 16'hCAFE, 16'h0);
    for (int c = 0; c <= 2; c++) begin
      apply(wc, idle);
      check_model($sformatf("rst pre c%0d", c));
      if (c < 2) advance();
    end
    reset = 1'b1;
    #1;
    check("rst mid-strobe", out_a, ex(1,1,1,0,1, 2'd0, 16'h0, 16'h0));
    reset = 1'b0;
    model_reset();
    first_wait = -1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) apply(wc, idle);
      check_model($sformatf("rst post c%0d", c));
      if (first_wait < 0 && out_a[34] == 1'b0) first_wait = c;
      advance();
    end
    check_int("rst post wait low cycle", first_wait, 4);
    for (int c = 0; c < 4; c++) begin
      apply(idle, idle);
      check_model($sformatf("rst drain c%0d", c));
      advance();
    end

    // Non-default timing on the second instance.
    wb = mk(1, 0, 1, 2'd1, 16'h7777, 16'h0);
    strobe_cnt = 0;
    first_wait = -1;
    for (int c = 0; c <= 12; c++) begin
      apply(idle, wb);
      check_model($sformatf("slow c%0d", c));
      o = out_b;
      if (o[36] == 1'b0) strobe_cnt++;
      if (first_wait < 0 && o[34] == 1'b0) first_wait = c;
      if (c == 11) check_int("slow cs_n idle c11", int'(o[38]), 1);
      if (c == 12) check_int("slow cs_n setup c12", int'(o[38]), 0);
      advance();
    end
    check_int("slow strobe width", strobe_cnt, 4);
    check_int("slow wait low cycle", first_wait, 9);
    for (int c = 0; c < 16; c++) begin
      apply(idle, idle);
      check_model($sformatf("slow drain c%0d", c));
      advance();
    end

    // Random traffic on both instances with occasional async reset.
    for (int c = 0; c < 600; c++) begin
      in_t ra, rbv;
      ra  = mk($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
               16'($urandom), 16'($urandom));
      rbv = mk($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
               16'($urandom), 16'($urandom));
      apply(ra, rbv);
      check_model($sformatf("rand c%0d", c));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_model($sformatf("rand reset c%0d", c));
        reset = 1'b0;
      end
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
